// File: rtl/cla_pipelined_adder.sv
// -----------------------------------------------------------------------------
// cla_pipelined_adder
//
// Pipelined carry-lookahead adder/subtractor. The operands are cut into
// SEG_W-bit segments, and each segment is resolved in its own pipeline stage.
// Within a segment the adder uses two lookahead levels:
//   level 1: a 4-bit CLA group gives per-bit carries plus a group G/P.
//   level 2: lookahead over the group G/P gives each group's carry-in and
//            the segment carry-out.
// The segment carry-out is registered into the next stage. Because of this,
// one operation is accepted per clock. A valid/ready handshake on both sides
// allows downstream back-pressure.
//
// Parameters
//   WIDTH  operand/result width. Must be a multiple of SEG_W.
//   SEG_W  bits resolved per stage. Must be a multiple of 4.
//   NSEG   (derived) WIDTH/SEG_W = pipeline depth = latency in cycles.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle
//   a, b       operands
//   sub        0: a+b+cin   1: a+~b+1 (cin ignored)
//   cin        carry-in for add mode
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   sum        result (modulo 2^WIDTH)
//   cout       carry out of the MSB (in sub mode, 1 = no borrow)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   zero       sum == 0
// -----------------------------------------------------------------------------
module cla_pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSEG = WIDTH / SEG_W;
  localparam int NGRP = SEG_W / 4;

  // The whole pipeline moves in lockstep. It only holds when a result is
  // sitting at the output and downstream refuses it.
  logic advance;

  // Operand stages 0..NSEG-1. Stage k still has to resolve segment k.
  // Segments below k in s_reg are finished result bits. Segments above k in
  // a_reg/b_reg are the skewed operands that are still waiting.
  logic [NSEG-1:0]  valid_reg;
  logic [WIDTH-1:0] a_reg     [NSEG];
  logic [WIDTH-1:0] b_reg     [NSEG];
  logic [WIDTH-1:0] s_reg     [NSEG];
  logic [NSEG-1:0]  carry_reg;

  // Combinational results of the segment that each stage resolves.
  logic [NSEG-1:0][WIDTH-1:0] s_next;
  logic [NSEG-1:0]            seg_cout;
  logic [NSEG-1:0]            seg_cmsb;

  // Output stage.
  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             zero_reg;

  assign advance  = !out_valid_reg || out_ready;
  assign in_ready = advance && !reset;

  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;
  assign zero      = zero_reg;

  // ---------------------------------------------------------------------------
  // Segment adders: stage gi resolves bits [gi*SEG_W +: SEG_W].
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
      logic [SEG_W-1:0] op_a;
      logic [SEG_W-1:0] op_b;
      logic [SEG_W-1:0] g;
      logic [SEG_W-1:0] p;
      logic [SEG_W-1:0] bit_c;
      logic [SEG_W-1:0] sum_seg;
      logic [NGRP-1:0]  grp_g;
      logic [NGRP-1:0]  grp_p;
      logic [NGRP:0]    grp_c;
      logic [WIDTH-1:0] s_ins;

      assign op_a = a_reg[gi][gi*SEG_W +: SEG_W];
      assign op_b = b_reg[gi][gi*SEG_W +: SEG_W];
      assign g    = op_a & op_b;
      assign p    = op_a ^ op_b;

      // First level: 4-bit CLA groups. The in-group carries come from the
      // group's carry-in, which the second level supplies.
      for (genvar gj = 0; gj < NGRP; gj++) begin : g_grp
        localparam int B = 4 * gj;

        assign grp_g[gj] = g[B+3]
                         | (p[B+3] & g[B+2])
                         | (p[B+3] & p[B+2] & g[B+1])
                         | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign grp_p[gj] = &p[B +: 4];

        assign bit_c[B]   = grp_c[gj];
        assign bit_c[B+1] = g[B] | (p[B] & grp_c[gj]);
        assign bit_c[B+2] = g[B+1]
                          | (p[B+1] & g[B])
                          | (p[B+1] & p[B] & grp_c[gj]);
        assign bit_c[B+3] = g[B+2]
                          | (p[B+2] & g[B+1])
                          | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & grp_c[gj]);
      end

      // Second level: flattened lookahead over the groups. The carry into
      // group j+1 is the OR over i<=j of G[i] & P[i+1..j], plus
      // P[0..j] & carry_in. The carry does not ripple from group to group.
      always_comb begin : second_level
        logic acc;
        logic prod;
        grp_c    = '0;
        grp_c[0] = carry_reg[gi];
        for (int j = 0; j < NGRP; j++) begin
          acc  = 1'b0;
          prod = 1'b1;
          for (int i = j; i >= 0; i--) begin
            acc  = acc | (prod & grp_g[i]);
            prod = prod & grp_p[i];
          end
          grp_c[j+1] = acc | (prod & carry_reg[gi]);
        end
      end

      assign sum_seg = p ^ bit_c;

      // Copy the partial result and drop in the newly resolved segment.
      always_comb begin
        s_ins                       = s_reg[gi];
        s_ins[gi*SEG_W +: SEG_W]    = sum_seg;
      end

      assign s_next[gi]   = s_ins;
      assign seg_cout[gi] = grp_c[NGRP];
      // Carry into the top bit of this segment. For the last segment, this is
      // the carry into bit WIDTH-1 that the overflow flag needs.
      assign seg_cmsb[gi] = bit_c[SEG_W-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pipeline registers. Data registers load only behind a valid beat. As a
  // result, bubbles leave the held values alone and the outputs keep their
  // last result while out_valid is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg     <= '0;
      carry_reg     <= '0;
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      zero_reg      <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        a_reg[k] <= '0;
        b_reg[k] <= '0;
        s_reg[k] <= '0;
      end
    end else if (advance) begin
      // Stage 0: subtraction is a + ~b + 1, so the inverted b and the forced
      // carry are captured here. Later stages then only ever add.
      valid_reg[0] <= in_valid;
      if (in_valid) begin
        a_reg[0]     <= a;
        b_reg[0]     <= sub ? ~b : b;
        s_reg[0]     <= '0;
        carry_reg[0] <= sub | cin;
      end

      for (int k = 1; k < NSEG; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        if (valid_reg[k-1]) begin
          a_reg[k]     <= a_reg[k-1];
          b_reg[k]     <= b_reg[k-1];
          s_reg[k]     <= s_next[k-1];
          carry_reg[k] <= seg_cout[k-1];
        end
      end

      out_valid_reg <= valid_reg[NSEG-1];
      if (valid_reg[NSEG-1]) begin
        sum_reg  <= s_next[NSEG-1];
        cout_reg <= seg_cout[NSEG-1];
        ovf_reg  <= seg_cmsb[NSEG-1] ^ seg_cout[NSEG-1];
        zero_reg <= ~|s_next[NSEG-1];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipelined_adder
//
// Self-checking bench for cla_pipelined_adder (WIDTH=32, SEG_W=8, NSEG=4).
// A monitor keeps a queue of expected results. It computes them with plain
// 33-bit arithmetic and checks every output beat. Directed scenarios add
// literal checks of values, latency, stall and reset behaviour.
// -----------------------------------------------------------------------------
module tb_cla_pipelined_adder;

  localparam int WIDTH = 32;
  localparam int SEG_W = 8;
  localparam int NSEG  = WIDTH / SEG_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  always #5 clk = ~clk;

  cla_pipelined_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  res_t exp_q[$];
  res_t mon_r;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: ordinary integer add/subtract. Overflow uses the sign rule.
  function automatic res_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic msub, input logic mcin);
    res_t r;
    logic [WIDTH:0] t;
    if (msub) begin
      t      = {1'b0, ma} - {1'b0, mb};
      r.sum  = t[WIDTH-1:0];
      r.cout = (ma >= mb);
      r.ovf  = (ma[WIDTH-1] != mb[WIDTH-1]) && (r.sum[WIDTH-1] != ma[WIDTH-1]);
    end else begin
      t      = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mcin};
      r.sum  = t[WIDTH-1:0];
      r.cout = t[WIDTH];
      r.ovf  = (ma[WIDTH-1] == mb[WIDTH-1]) && (r.sum[WIDTH-1] != ma[WIDTH-1]);
    end
    r.zero = (r.sum == '0);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: samples on the falling edge, half a cycle away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        check("in_ready_reset", in_ready, 0);
      end else begin
        check("in_ready_rule", in_ready, (!out_valid || out_ready));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", out_valid, 0);
          end else begin
            mon_r = exp_q[0];
            check("mon_sum",  sum,  mon_r.sum);
            check("mon_cout", cout, mon_r.cout);
            check("mon_ovf",  ovf,  mon_r.ovf);
            check("mon_zero", zero, mon_r.zero);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, cin));
      end
    end
  end

  // One beat through an idle pipeline with literal expectations and latency.
  task automatic run_single(input string name, input logic [WIDTH-1:0] ta,
                            input logic [WIDTH-1:0] tb, input logic tsub, input logic tcin,
                            input logic [WIDTH-1:0] esum, input logic ecout,
                            input logic eovf, input logic ezero);
    res_t m;
    int   lat;
    m = model(ta, tb, tsub, tcin);
    check({name, "_model_sum"},  m.sum,  esum);
    check({name, "_model_cout"}, m.cout, ecout);
    check({name, "_model_ovf"},  m.ovf,  eovf);
    @(posedge clk); #1;
    a = ta; b = tb; sub = tsub; cin = tcin; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, NSEG);
    check({name, "_sum"},  sum,  esum);
    check({name, "_cout"}, cout, ecout);
    check({name, "_ovf"},  ovf,  eovf);
    check({name, "_zero"}, zero, ezero);
    $display("txn %s: a=%h b=%h sub=%0d cin=%0d -> sum=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
             name, ta, tb, tsub, tcin, sum, cout, ovf, zero, lat);
    @(posedge clk); #1;
  endtask

  // Collects eight output transfers and expects sums 0,2,...,14 in order.
  // It returns the cycle span from the first transfer to the last.
  task automatic collect8(input string name, output int span);
    int got;
    int k;
    int first_k;
    got = 0; k = 0; first_k = 0; span = -1;
    #1;
    while (got < 8 && k < 80) begin
      if (out_valid && out_ready) begin
        if (got == 0) first_k = k;
        check({name, "_sum"}, sum, 2 * got);
        $display("txn %s: beat %0d sum=%0d", name, got, sum);
        got++;
        span = k - first_k;
      end
      @(posedge clk); #2;
      k++;
    end
    check({name, "_count"}, got, 8);
  endtask

  int span4;
  int span5;
  int cyc5;
  int idx5;
  logic acc5;
  int sent;
  int guard;
  logic acc_r;

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum",  sum,  0);
    check("reset_cout", cout, 0);
    check("reset_ovf",  ovf,  0);
    check("reset_zero", zero, 0);
    check("reset_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", in_ready, 1);

    // Directed single beats
    run_single("add_seg_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0,
               32'h0001_0000, 1'b0, 1'b0, 1'b0);
    run_single("add_full_ripple", 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1,
               32'h0, 1'b1, 1'b0, 1'b1);
    run_single("sub_ovf", 32'h8000_0000, 32'h1, 1'b1, 1'b0,
               32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_single("sub_borrow", 32'h5, 32'h7, 1'b1, 1'b1,
               32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_single("add_pos_ovf", 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1,
               32'h8000_0000, 1'b0, 1'b1, 1'b0);

    // Back-to-back stream with no back-pressure
    @(posedge clk); #1;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          in_valid = 1'b1; a = i; b = i; sub = 1'b0; cin = 1'b0;
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      collect8("stream", span4);
    join
    check("stream_consecutive_span", span4, 7);
    @(posedge clk); #1;
    check("stream_idle_after", out_valid, 0);

    // Same stream with out_ready low during cycles 5..8
    @(posedge clk); #1;
    fork
      begin
        cyc5 = 0; idx5 = 0;
        while ((idx5 < 8 || cyc5 <= 8) && cyc5 < 100) begin
          out_ready = !(cyc5 >= 5 && cyc5 <= 8);
          if (idx5 < 8) begin
            in_valid = 1'b1; a = idx5; b = idx5; sub = 1'b0; cin = 1'b0;
          end else begin
            in_valid = 1'b0;
          end
          #1;
          acc5 = in_valid && in_ready;
          if (cyc5 >= 5 && cyc5 <= 8) check("stall_in_ready", in_ready, 0);
          @(posedge clk); #1;
          if (acc5) idx5++;
          cyc5++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      collect8("stall", span5);
    join
    repeat (2) @(posedge clk);
    #1;
    check("stall_idle_after", out_valid, 0);

    // Reset with three beats in flight
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 100 + i; b = i; sub = 1'b0; cin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("midrst_no_ghost", out_valid, 0);
    end

    // Random traffic with random back-pressure
    sent = 0; guard = 0;
    in_valid = 1'b0;
    while (sent < 10000 && guard < 60000) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (!in_valid && $urandom_range(0, 9) < 8) begin
        in_valid = 1'b1;
        a = rand_op(); b = rand_op();
        sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      end
      #1;
      acc_r = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      if (acc_r) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    check("random_sent", sent, 10000);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (NSEG + 3) @(posedge clk);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
